if_fetch_queue: RTL and testbench

//  Parametrised instruction-fetch stage with a prefetch queue; generational successor to the single-register IF stage.
//  - Owns the fetch PC and issues sequential requests to a fixed 1-cycle-latency instruction memory.
//  - Buffers fetched {instr, pc} pairs in a DEPTH-entry FIFO and hands them to decode over a valid/ready handshake.
//  - Sits between the imem port and the IF/ID boundary. A redirect from EX flushes the queue and kills any in-flight fetch.

---
 rtl/if_fetch_queue.sv | 132 +++++++++++++
 tb/tb_if_fetch_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_queue
//  Brief    : Instruction-fetch stage with a DEPTH-entry prefetch queue.
//             Owns the fetch PC, issues sequential requests to a fixed
//             1-cycle-latency instruction memory, buffers {instr, pc} pairs
//             and hands them to decode over a valid/ready handshake.
//             A redirect flushes the queue and kills the in-flight fetch.
//  Revision : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
  parameter int                 PC_W      = 16,
  parameter int                 INSTR_W   = 32,
  parameter int                 DEPTH     = 4,
  parameter int                 PC_STEP   = 4,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect,
  input  logic [PC_W-1:0]            redirect_pc,
  input  logic                       hold_fetch,
  output logic                       imem_req,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [INSTR_W-1:0]         imem_rdata,
  output logic [INSTR_W-1:0]         instr_D,
  output logic [PC_W-1:0]            pc_D,
  output logic                       instr_valid_D,
  input  logic                       instr_ready_D,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  // Occupancy plus in-flight credit needs one extra bit to avoid overflow.
  localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);
  localparam logic [PC_W-1:0] PC_INC      = PC_W'(PC_STEP);

  // Fetch-side state
  logic [PC_W-1:0]    fetch_pc;
  logic               inflight_valid;
  logic [PC_W-1:0]    inflight_pc;

  // Queue storage and bookkeeping
  logic [INSTR_W-1:0] fifo_instr [DEPTH];
  logic [PC_W-1:0]    fifo_pc    [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;

  // Handshake/control wires
  logic [CNT_W:0]     occupancy;
  logic               queue_nonempty;
  logic               push;
  logic               pop;

  // The credit check ignores a same-cycle pop: an issued request always has
  // a guaranteed slot, so the queue can never be pushed while full.
  always_comb begin
    occupancy = {1'b0, count} + (CNT_W + 1)'(inflight_valid);
    imem_req  = !reset && !redirect && !hold_fetch && (occupancy < CREDIT_LIMIT);
    imem_addr = fetch_pc;
  end

  // Push the returning word unless a redirect kills it; pops are ignored
  // while a redirect flushes the queue.
  always_comb begin
    queue_nonempty = (count != '0);
    push           = inflight_valid && !redirect;
    pop            = queue_nonempty && instr_ready_D && !redirect;
  end

  // Head-of-queue presentation; a NOP bubble is shown while empty or in reset.
  always_comb begin
    instr_valid_D = !reset && queue_nonempty;
    instr_D       = NOP_INSTR;
    pc_D          = '0;
    if (instr_valid_D) begin
      instr_D = fifo_instr[rd_ptr];
      pc_D    = fifo_pc[rd_ptr];
    end
  end

  // Fetch PC and in-flight tracking; redirect reloads the PC even under hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc       <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
    end else if (redirect) begin
      fetch_pc       <= redirect_pc;
      inflight_valid <= 1'b0;
    end else if (imem_req) begin
      fetch_pc       <= fetch_pc + PC_INC;
      inflight_pc    <= fetch_pc;
      inflight_valid <= 1'b1;
    end else begin
      inflight_valid <= 1'b0;
    end
  end

  // Queue storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= inflight_pc;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH (power of 2).
  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch_queue
//  Brief    : Self-checking bench for if_fetch_queue: transaction-level
//             queue model checked every cycle plus directed literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] SALT  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        hold_fetch;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_D;
  logic [15:0] pc_D;
  logic        instr_valid_D;
  logic        instr_ready_D;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  if_fetch_queue dut (
    .clk           (clk),
    .reset         (reset),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .hold_fetch    (hold_fetch),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instr_D       (instr_D),
    .pc_D          (pc_D),
    .instr_valid_D (instr_valid_D),
    .instr_ready_D (instr_ready_D),
    .count         (count)
  );

  always #5 clk = ~clk;

  // 1-cycle memory; unrequested cycles return junk so stray pushes show up.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= {16'h0000, imem_addr} ^ SALT;
    else          imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: list of PCs held by decode-side queue, plus one pending fetch.
  // The instruction word is a pure function of the PC, so only PCs are kept.
  logic [15:0] m_fetch;
  logic        m_pend;
  logic [15:0] m_pend_pc;
  logic [15:0] mq[$];

  always @(negedge clk) begin : model
    logic        e_valid, e_req;
    logic [15:0] e_pc;
    logic [31:0] e_instr;
    if (reset) begin
      chk("rst_req",   {31'b0, imem_req},      32'd0);
      chk("rst_valid", {31'b0, instr_valid_D}, 32'd0);
      chk("rst_instr", instr_D,                NOP);
      chk("rst_pc",    {16'b0, pc_D},          32'd0);
      m_fetch = 16'h0000;
      m_pend  = 1'b0;
      mq.delete();
    end else begin
      e_valid = (mq.size() != 0);
      e_pc    = e_valid ? mq[0] : 16'h0000;
      e_instr = e_valid ? ({16'h0000, e_pc} ^ SALT) : NOP;
      e_req   = !redirect && !hold_fetch && ((mq.size() + int'(m_pend)) < DEPTH);
      chk("valid", {31'b0, instr_valid_D}, {31'b0, e_valid});
      chk("instr", instr_D, e_instr);
      chk("pc",    {16'b0, pc_D},  {16'b0, e_pc});
      chk("count", {29'b0, count}, 32'(mq.size()));
      chk("req",   {31'b0, imem_req}, {31'b0, e_req});
      if (e_req) chk("addr", {16'b0, imem_addr}, {16'b0, m_fetch});
      if (redirect) begin
        mq.delete();
        m_pend  = 1'b0;
        m_fetch = redirect_pc;
      end else begin
        chk("no_push_full", {31'b0, (m_pend && mq.size() == DEPTH)}, 32'd0);
        if (e_valid && instr_ready_D) void'(mq.pop_front());
        if (m_pend) mq.push_back(m_pend_pc);
        if (e_req) begin
          m_pend_pc = m_fetch;
          m_fetch   = m_fetch + 16'd4;
          m_pend    = 1'b1;
        end else begin
          m_pend = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed stimulus with literal expectations
  initial begin : stim
    logic [15:0] h;
    logic [15:0] a;
    bit          hit;
    reset = 1'b1; redirect = 1'b0; redirect_pc = 16'h0; hold_fetch = 1'b0;
    instr_ready_D = 1'b1;

    // 1: reset 2 cycles then sequential stream
    tick(); tick();
    reset = 1'b0; #1;
    chk("t1_req0",  {31'b0, imem_req}, 32'd1);
    chk("t1_addr0", {16'b0, imem_addr}, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      tick(); #1;
      if (k == 1) chk("t1_addr1", {16'b0, imem_addr}, 32'h4);
      if (k >= 2) begin
        chk("t1_pc",    {16'b0, pc_D}, 32'(4 * (k - 2)));
        chk("t1_instr", instr_D, 32'(4 * (k - 2)) ^ SALT);
      end
    end

    // 2: decode stalls 8 cycles, then release
    tick();
    instr_ready_D = 1'b0; #1;
    h = pc_D;
    repeat (8) tick();
    #1;
    chk("t2_count", {29'b0, count}, 32'd4);
    chk("t2_req",   {31'b0, imem_req}, 32'd0);
    instr_ready_D = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      #1;
      chk("t2_pc", {16'b0, pc_D}, {16'b0, h + 16'(4 * i)});
    end

    // 3: redirect with 3 queued + 1 in flight
    tick();
    instr_ready_D = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      tick(); #1;
      if (count == 3'd3) hit = 1'b1;
    end
    chk("t3_wait_count3", {29'b0, count}, 32'd3);
    redirect = 1'b1; redirect_pc = 16'h0040; #1;
    chk("t3_req_n", {31'b0, imem_req}, 32'd0);
    tick();
    redirect = 1'b0; instr_ready_D = 1'b1; #1;
    chk("t3_count", {29'b0, count}, 32'd0);
    chk("t3_valid", {31'b0, instr_valid_D}, 32'd0);
    chk("t3_addr",  {16'b0, imem_addr}, 32'h40);
    tick(); tick(); #1;
    chk("t3_pc",    {16'b0, pc_D}, 32'h40);
    chk("t3_instr", instr_D, 32'h40 ^ SALT);

    // 4: hold fetch for 3 cycles while draining
    tick(); #1;
    a = imem_addr;
    hold_fetch = 1'b1; #1;
    chk("t4_req_h0", {31'b0, imem_req}, 32'd0);
    tick(); #1;
    chk("t4_req_h1", {31'b0, imem_req}, 32'd0);
    tick(); #1;
    chk("t4_req_h2", {31'b0, imem_req}, 32'd0);
    chk("t4_drained", {29'b0, count}, 32'd0);
    tick();
    hold_fetch = 1'b0; #1;
    chk("t4_resume_req",  {31'b0, imem_req}, 32'd1);
    chk("t4_resume_addr", {16'b0, imem_addr}, {16'b0, a});

    // 5: redirect (under hold) to top of address space, PC wraps
    tick();
    redirect = 1'b1; redirect_pc = 16'hFFFC; hold_fetch = 1'b1;
    tick();
    redirect = 1'b0; hold_fetch = 1'b0;
    tick(); tick(); #1;
    chk("t5_pc0",    {16'b0, pc_D}, 32'hFFFC);
    chk("t5_instr0", instr_D, 32'h0000_FFFC ^ SALT);
    tick(); #1;
    chk("t5_pc1", {16'b0, pc_D}, 32'h0000);
    tick(); #1;
    chk("t5_pc2", {16'b0, pc_D}, 32'h0004);

    // 6: reset mid-stream with a full queue
    instr_ready_D = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      tick(); #1;
      if (count == 3'd4) hit = 1'b1;
    end
    chk("t6_full", {29'b0, count}, 32'd4);
    reset = 1'b1; #1;
    chk("t6_rst_valid", {31'b0, instr_valid_D}, 32'd0);
    chk("t6_rst_instr", instr_D, NOP);
    tick();
    reset = 1'b0; #1;
    chk("t6_count", {29'b0, count}, 32'd0);
    chk("t6_valid", {31'b0, instr_valid_D}, 32'd0);
    chk("t6_instr", instr_D, NOP);
    chk("t6_req",   {31'b0, imem_req}, 32'd1);
    chk("t6_addr",  {16'b0, imem_addr}, 32'h0);
    instr_ready_D = 1'b1;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
